uart_loader: RTL and testbench
==============================

# uart_loader

Boot-time program loader that sits directly upstream of the SoC RAM. It receives a framed program image over a UART RX line, assembles little-endian 32-bit words and writes them through a RAM write port starting at word 0. It holds the CPU in reset until the image is complete, which replaces the simulation-only ELF backdoor with a synthesizable load path.

## Interface
- `XLEN`, 32, data word width; only 32 is supported.
- `RAM_SIZE`, 'h600, RAM depth in words; the address width is `AW = $clog2(RAM_SIZE)`.
- `CLKS_PER_BIT`, 16, `CLK` cycles per UART bit; must be even and ≥ 4.

Ports:
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RESETn`  in  1  asynchronous, active-low reset.
- `RX`  in  1  UART line, 8N1, idle high, asynchronous to `CLK`.
- `MEM_WE`  out  1  RAM write strobe, one cycle per word.
- `MEM_ADDR`  out  AW  RAM word address.
- `MEM_WDATA`  out  XLEN  RAM write data.
- `CPU_RESETn`  out  1  CPU reset; low until the load completes.
- `BUSY`  out  1  high while a frame is in progress (states LEN or DATA).
- `ERROR`  out  1  sticky error flag; cleared only by `RESETn`.

## Operation
- Reset values: `MEM_WE`=0, `MEM_ADDR`=0, `MEM_WDATA`=0, `CPU_RESETn`=0, `BUSY`=0, `ERROR`=0.
- `RX` passes through a 2-flop synchronizer before any use.
- **UART receiver**
  - States: IDLE → START → DATA → STOP.
  - A falling edge of the synchronized `RX` enters START.
  - At count `CLKS_PER_BIT/2`, the line is sampled. If it is high, this is a false start and the receiver returns to IDLE.
  - In DATA, 8 bits are sampled every `CLKS_PER_BIT` cycles, LSB first.
  - In STOP, the stop bit is sampled at the same spacing:
    - stop bit = 1: `byte_valid` pulses for one cycle.
    - stop bit = 0: `frame_err` pulses for one cycle.
  - The receiver returns to IDLE in the cycle after the stop sample.
- **Loader FSM**
  - WAIT_SYNC: discard bytes until one equals `SYNC_BYTE` (8'hA5), then go to LEN.
  - LEN: collect a 4-byte word count `N`, little-endian.
    - `N`=0: go to DONE.
    - `N`>`RAM_SIZE`: go to ERR.
    - Otherwise: go to DATA.
  - DATA:
    - Bytes fill `MEM_WDATA` from byte 0 upward: the first byte goes to [7:0], the fourth to [31:24].
    - After the fourth byte, `MEM_WE` pulses.
    - After each write, the address increments; the frame ends after `N` words and the FSM goes to DONE.
  - DONE: `CPU_RESETn`=1. All further `RX` activity is ignored until `RESETn`.
  - ERR: `ERROR`=1 and `CPU_RESETn` stays 0. Re-entry is from reset only.
- `frame_err` handling:
  - In LEN or DATA: go to ERR.
  - In WAIT_SYNC: ignored (line noise before sync).
- The address wraps only by frame design: `N`≤`RAM_SIZE` guarantees `MEM_ADDR` never exceeds `RAM_SIZE-1`.
- Reset mid-frame: all state returns to reset values immediately. A partially received word is discarded and never written.

## Timing
- Synchronizer latency is 2 cycles from the `RX` pin to detection.
- One UART byte occupies 10×`CLKS_PER_BIT` cycles; with default parameters this is 160 cycles.
- `MEM_WE`, `MEM_ADDR` and `MEM_WDATA` are registered. `MEM_WE` is high exactly one cycle, the cycle after the `byte_valid` of the fourth byte. `MEM_ADDR`/`MEM_WDATA` are stable during that cycle.
- `MEM_ADDR` increments in the cycle after `MEM_WE`, so consecutive words are ≥ 4 bytes apart. No back-pressure is needed.
- `CPU_RESETn` rises in the cycle after the last `MEM_WE`. For `N`=0, it rises the cycle after the fourth length byte's `byte_valid`.
- `ERROR` rises the cycle after the offending `frame_err` or length byte.
- `BUSY` falls in the same cycle that DONE or ERR is entered.

## Structure
- Package `loader_pkg`:
  - `loader_state_t` (WAIT_SYNC, LEN, DATA, DONE, ERR)
  - `uart_state_t`
  - `SYNC_BYTE`
- Sub-module `uart_rx`:
  - Parameter `CLKS_PER_BIT`.
  - Inputs `CLK`, `RESETn`, `RX`.
  - Outputs `DATA[7:0]`, `VALID`, `FRAME_ERR`.
  - Contains the synchronizer and bit timing.
- `uart_loader` contains only the framing FSM, the word assembly and the RAM port.

## Test plan
- Normal load: A5, 02 00 00 00, 78 56 34 12, EF BE AD DE → exactly two `MEM_WE` pulses:
  - addr 0 = 32'h12345678.
  - addr 1 = 32'hDEADBEEF.
  - Then `CPU_RESETn`=1, `ERROR`=0.
- Noise before sync: bytes 00 FF 3C, then a valid 1-word frame → no writes before A5, one write to addr 0.
- Empty image: A5 00 00 00 00 → no `MEM_WE`; `CPU_RESETn` rises within 1 cycle of the last length byte.
- Oversize length: A5 01 06 00 00 (`N`='h601 > `RAM_SIZE`) → `ERROR`=1, `CPU_RESETn`=0, no writes.
- Framing error: the stop bit is driven 0 on the 2nd data byte of a 1-word frame → `ERROR`=1, no `MEM_WE`.
- Glitch and reset:
  - A 3-cycle low glitch on idle `RX` → no byte is received.
  - Assert `RESETn` after 2 data bytes, then send a full 1-word frame → one write to addr 0 containing only the new frame's data.

Source files
------------

// File: rtl/loader_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// loader_pkg: shared state types and constants for the UART boot loader. Rev 1.0
// ---------------------------------------------------------------------------
package loader_pkg;

  typedef enum logic [2:0] {
    L_WAIT_SYNC = 3'd0,
    L_LEN       = 3'd1,
    L_DATA      = 3'd2,
    L_DONE      = 3'd3,
    L_ERR       = 3'd4
  } loader_state_t;

  typedef enum logic [1:0] {
    U_IDLE  = 2'd0,
    U_START = 2'd1,
    U_DATA  = 2'd2,
    U_STOP  = 2'd3
  } uart_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx: 8N1 receiver with 2-flop input synchronizer and mid-bit sampling. Rev 1.0
// ---------------------------------------------------------------------------
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;

  // Flops reset high so an idle line is never mistaken for a start edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= U_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      DATA      <= '0;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        U_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_sync) state <= U_START;
        end
        U_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? U_IDLE : U_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            DATA    <= {rx_sync, DATA[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= U_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (cnt == LAST) begin
            cnt       <= '0;
            VALID     <= rx_sync;
            FRAME_ERR <= ~rx_sync;
            state     <= U_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= U_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_loader: framed UART program loader driving a RAM write port. Rev 1.0
// ---------------------------------------------------------------------------
module uart_loader
  import loader_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RAM_SIZE     = 'h600,
  parameter int CLKS_PER_BIT = 16,
  localparam int AW          = $clog2(RAM_SIZE)
) (
  input  logic            CLK,
  input  logic            RESETn,
  input  logic            RX,
  output logic            MEM_WE,
  output logic [AW-1:0]   MEM_ADDR,
  output logic [XLEN-1:0] MEM_WDATA,
  output logic            CPU_RESETn,
  output logic            BUSY,
  output logic            ERROR
);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ferr;
  loader_state_t state;
  logic [1:0]    byte_cnt;
  logic [23:0]   len_lo;
  logic [AW:0]   words_left;
  logic [31:0]   len_word;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .RX        (RX),
    .DATA      (rx_data),
    .VALID     (rx_valid),
    .FRAME_ERR (rx_ferr)
  );

  // Full length as it stands once the fourth (most significant) byte arrives.
  assign len_word = {rx_data, len_lo};

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= L_WAIT_SYNC;
      byte_cnt   <= '0;
      len_lo     <= '0;
      words_left <= '0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      CPU_RESETn <= 1'b0;
      BUSY       <= 1'b0;
      ERROR      <= 1'b0;
    end else begin
      MEM_WE <= 1'b0;
      case (state)
        L_WAIT_SYNC: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state    <= L_LEN;
            BUSY     <= 1'b1;
            byte_cnt <= '0;
          end
        end
        L_LEN: begin
          if (rx_ferr) begin
            state <= L_ERR;
            ERROR <= 1'b1;
            BUSY  <= 1'b0;
          end else if (rx_valid) begin
            byte_cnt <= byte_cnt + 1'b1;
            case (byte_cnt)
              2'd0: len_lo[7:0]   <= rx_data;
              2'd1: len_lo[15:8]  <= rx_data;
              2'd2: len_lo[23:16] <= rx_data;
              default: begin
                if (len_word == 32'd0) begin
                  state      <= L_DONE;
                  CPU_RESETn <= 1'b1;
                  BUSY       <= 1'b0;
                end else if (len_word > 32'(RAM_SIZE)) begin
                  state <= L_ERR;
                  ERROR <= 1'b1;
                  BUSY  <= 1'b0;
                end else begin
                  state      <= L_DATA;
                  words_left <= len_word[AW:0];
                end
              end
            endcase
          end
        end
        L_DATA: begin
          // The write cycle is consumed here; the address holds on the last word.
          if (MEM_WE) begin
            if (words_left == (AW+1)'(1)) begin
              state      <= L_DONE;
              CPU_RESETn <= 1'b1;
              BUSY       <= 1'b0;
            end else begin
              MEM_ADDR   <= MEM_ADDR + 1'b1;
              words_left <= words_left - 1'b1;
            end
          end else if (rx_ferr) begin
            state <= L_ERR;
            ERROR <= 1'b1;
            BUSY  <= 1'b0;
          end else if (rx_valid) begin
            MEM_WDATA[8*byte_cnt +: 8] <= rx_data;
            byte_cnt                   <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) MEM_WE <= 1'b1;
          end
        end
        L_DONE, L_ERR: ;
        default: state <= L_WAIT_SYNC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_loader: random and directed frames checked against a byte-stream model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_loader;

  localparam int CPB      = 16;
  localparam int RAM_SIZE = 'h600;
  localparam int AW       = $clog2(RAM_SIZE);
  localparam logic [7:0] SYNC = 8'hA5;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          RX = 1'b1;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_WDATA;
  logic          CPU_RESETn;
  logic          BUSY;
  logic          ERROR;

  uart_loader #(.XLEN(32), .RAM_SIZE(RAM_SIZE), .CLKS_PER_BIT(CPB)) dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .RX         (RX),
    .MEM_WE     (MEM_WE),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WDATA  (MEM_WDATA),
    .CPU_RESETn (CPU_RESETn),
    .BUSY       (BUSY),
    .ERROR      (ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] sb_byte[$];
  bit         sb_ferr[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_we_cyc = -1;
  int         we_count = 0;
  int         sync_idx = -1;
  int         glitch_at = -1;
  logic       prev_we = 1'b0;
  logic       prev_cpu = 1'b0;
  wr_t        mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every write against the model queue, plus per-cycle invariants.
  always @(negedge CLK) begin
    cyc++;
    if (!RESETn) begin
      last_we_cyc = -1;
      prev_we     = 1'b0;
      prev_cpu    = 1'b0;
    end else begin
      if (MEM_WE) begin
        we_count++;
        chk("we_single_cycle", prev_we, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", MEM_ADDR, MEM_WDATA);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", MEM_ADDR, mon_e.addr);
          chk("wr_data", MEM_WDATA, mon_e.data);
        end
        last_we_cyc = cyc;
      end
      if (CPU_RESETn && !prev_cpu && last_we_cyc >= 0)
        chk("cpu_rise_after_last_we", cyc - last_we_cyc, 1);
      chk("busy_with_cpu_run", BUSY & CPU_RESETn, 0);
      chk("error_with_cpu_run", ERROR & CPU_RESETn, 0);
      prev_we  = MEM_WE;
      prev_cpu = CPU_RESETn;
    end
  end

  task automatic add(input logic [7:0] b, input bit ferr = 1'b0);
    sb_byte.push_back(b);
    sb_ferr.push_back(ferr);
  endtask

  task automatic clear_sb();
    sb_byte.delete();
    sb_ferr.delete();
    glitch_at = -1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ferr);
    @(negedge CLK);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = ~ferr;
    repeat (CPB) @(negedge CLK);
    RX = 1'b1;
    if (ferr) repeat (2*CPB) @(negedge CLK);
    repeat ($urandom_range(0, 4)) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETn = 1'b0;
    RX     = 1'b1;
    repeat (3) @(negedge CLK);
    RESETn = 1'b1;
    exp_q.delete();
  endtask

  // Byte-stream model: hunt sync, little-endian length, then whole words.
  task automatic model_run(output bit done, output bit err);
    int          i;
    int          n;
    logic [31:0] len;
    logic [31:0] word;
    wr_t         w;
    done = 1'b0;
    err  = 1'b0;
    n    = sb_byte.size();
    i    = 0;
    sync_idx = -1;
    while (i < n && !(sb_byte[i] == SYNC && !sb_ferr[i])) i++;
    if (i >= n) return;
    sync_idx = i;
    i++;
    len = '0;
    for (int k = 0; k < 4; k++) begin
      if (i >= n) return;
      if (sb_ferr[i]) begin err = 1'b1; return; end
      len[8*k +: 8] = sb_byte[i];
      i++;
    end
    if (len == 0) begin done = 1'b1; return; end
    if (len > RAM_SIZE) begin err = 1'b1; return; end
    for (int wi = 0; wi < int'(len); wi++) begin
      word = '0;
      for (int k = 0; k < 4; k++) begin
        if (i >= n) return;
        if (sb_ferr[i]) begin err = 1'b1; return; end
        word[8*k +: 8] = sb_byte[i];
        i++;
      end
      w.addr = AW'(wi);
      w.data = word;
      exp_q.push_back(w);
    end
    done = 1'b1;
  endtask

  task automatic run_frame(input string tag, output bit done, output bit err);
    model_run(done, err);
    for (int k = 0; k < sb_byte.size(); k++) begin
      send_byte(sb_byte[k], sb_ferr[k]);
      if (k == sync_idx) chk({tag, "_busy_after_sync"}, BUSY, 1);
      if (k == glitch_at) begin
        @(negedge CLK);
        RX = 1'b0;
        repeat (3) @(negedge CLK);
        RX = 1'b1;
        repeat (2*CPB) @(negedge CLK);
      end
    end
    chk({tag, "_cpu_prompt"}, CPU_RESETn, done);
    repeat (2*CPB) @(negedge CLK);
    chk({tag, "_writes_left"}, exp_q.size(), 0);
    chk({tag, "_cpu_resetn"}, CPU_RESETn, done);
    chk({tag, "_error"}, ERROR, err);
    if (done || err) chk({tag, "_busy_idle"}, BUSY, 0);
  endtask

  initial begin
    bit d, e;
    int base;
    RESETn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_mem_we", MEM_WE, 0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    chk("rst_mem_wdata", MEM_WDATA, 0);
    chk("rst_cpu_resetn", CPU_RESETn, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_error", ERROR, 0);
    RESETn = 1'b1;

    // Normal two-word load, with the model pinned to literal words.
    do_reset();
    clear_sb();
    add(SYNC); add(8'h02); add(8'h00); add(8'h00); add(8'h00);
    add(8'h78); add(8'h56); add(8'h34); add(8'h12);
    add(8'hEF); add(8'hBE); add(8'hAD); add(8'hDE);
    model_run(d, e);
    chk("model_word0", exp_q[0].data, 32'h12345678);
    chk("model_word1", exp_q[1].data, 32'hDEADBEEF);
    chk("model_addr1", exp_q[1].addr, 1);
    exp_q.delete();
    base = we_count;
    run_frame("normal", d, e);
    chk("normal_we_count", we_count - base, 2);

    // Noise ahead of the sync byte.
    do_reset();
    clear_sb();
    add(8'h00); add(8'hFF); add(8'h3C);
    add(SYNC); add(8'h01); add(8'h00); add(8'h00); add(8'h00);
    add(8'h11); add(8'h22); add(8'h33); add(8'h44);
    base = we_count;
    run_frame("noise", d, e);
    chk("noise_we_count", we_count - base, 1);

    // Empty image.
    do_reset();
    clear_sb();
    add(SYNC); add(8'h00); add(8'h00); add(8'h00); add(8'h00);
    base = we_count;
    run_frame("empty", d, e);
    chk("model_empty_done", d, 1);
    chk("empty_we_count", we_count - base, 0);

    // Oversize length 'h601.
    do_reset();
    clear_sb();
    add(SYNC); add(8'h01); add(8'h06); add(8'h00); add(8'h00);
    add(8'h12); add(8'h34); add(8'h56); add(8'h78);
    run_frame("oversize", d, e);
    chk("model_oversize_err", e, 1);

    // Bad stop bit on the second data byte.
    do_reset();
    clear_sb();
    add(SYNC); add(8'h01); add(8'h00); add(8'h00); add(8'h00);
    add(8'h11); add(8'h22, 1'b1); add(8'h33); add(8'h44);
    base = we_count;
    run_frame("framing", d, e);
    chk("model_framing_err", e, 1);
    chk("framing_we_count", we_count - base, 0);

    // Short low glitch while waiting for length must not become a byte.
    do_reset();
    clear_sb();
    add(SYNC); add(8'h01); add(8'h00); add(8'h00); add(8'h00);
    add(8'hDE); add(8'hC0); add(8'hAD); add(8'h0B);
    glitch_at = 0;
    run_frame("glitch", d, e);

    // Reset in the middle of a word, then a fresh frame.
    do_reset();
    send_byte(SYNC, 1'b0);
    send_byte(8'h01, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    @(negedge CLK);
    RESETn = 1'b0;
    #1;
    chk("midrst_wdata", MEM_WDATA, 0);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_addr", MEM_ADDR, 0);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    exp_q.delete();
    clear_sb();
    add(SYNC); add(8'h01); add(8'h00); add(8'h00); add(8'h00);
    add(8'h0D); add(8'hF0); add(8'hAD); add(8'h0B);
    base = we_count;
    run_frame("after_rst", d, e);
    chk("after_rst_we_count", we_count - base, 1);

    // Randomized frames: noise, length mode, payload, occasional bad stop.
    for (int it = 0; it < 6; it++) begin
      int          noise;
      int          mode;
      int          nw;
      logic [7:0]  b;
      logic [31:0] len;
      do_reset();
      clear_sb();
      noise = $urandom_range(0, 3);
      for (int k = 0; k < noise; k++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h5A;
        add(b, $urandom_range(0, 3) == 0);
      end
      add(SYNC);
      mode = $urandom_range(0, 5);
      if (mode == 0) len = 32'd0;
      else if (mode == 1) len = 32'(RAM_SIZE + 1 + $urandom_range(0, 1000));
      else len = 32'($urandom_range(1, 3));
      for (int k = 0; k < 4; k++) add(len[8*k +: 8]);
      nw = (mode >= 2) ? int'(len) : 1;
      for (int k = 0; k < 4*nw; k++) add(8'($urandom));
      if ($urandom_range(0, 3) == 0)
        sb_ferr[$urandom_range(noise + 1, sb_byte.size() - 1)] = 1'b1;
      run_frame("random", d, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
